// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller:
// exception codes, redirect vectors, FSM states and the vector map.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS     = 32'h0000_0008;
  localparam logic [31:0] EXC_BP      = 32'h0000_0009;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
  localparam logic [31:0] EXC_BOOT_11 = 32'h0000_0011;
  localparam logic [31:0] EXC_GEN_12  = 32'h0000_0012;
  localparam logic [31:0] EXC_BOOT_13 = 32'h0000_0013;
  localparam logic [31:0] EXC_GEN_14  = 32'h0000_0014;
  localparam logic [31:0] EXC_GEN_15  = 32'h0000_0015;
  localparam logic [31:0] EXC_REFETCH = 32'hffff_ffff;

  localparam logic [31:0] VEC_GENERAL = 32'hbfc0_0380;
  localparam logic [31:0] VEC_BOOT    = 32'hbfc0_0200;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REDIRECT
  } ctrl_state_e;

  function automatic logic [31:0] exc_vector(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] pc);
    logic [31:0] vec;
    case (code)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV,
      EXC_TRAP, EXC_GEN_12, EXC_GEN_14, EXC_GEN_15: vec = VEC_GENERAL;
      EXC_BOOT_11, EXC_BOOT_13:                     vec = VEC_BOOT;
      EXC_ERET:                                     vec = epc;
      EXC_REFETCH:                                  vec = pc + 32'd4;
      default:                                      vec = 32'h0;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = sat_inc(count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 32'h0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl_v2.sv
// Pipeline stall/flush controller: per-source freeze masks, a drain-aware
// exception redirect FSM, stall/flush performance counters and a stall watchdog.
module pipe_ctrl_v2
  import pipe_ctrl_pkg::*;
#(
  parameter int                   NUM_STAGES   = 9,
  parameter int                   NUM_SRC      = 5,
  parameter logic [8*NUM_SRC-1:0] STALL_DEPTHS = {8'd4, 8'd5, 8'd8, 8'd8, 8'd8},
  parameter int                   TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_SRC-1:0]    stall_req,
  input  logic                  mem_busy,
  input  logic [31:0]           excepttype_i,
  input  logic [31:0]           cp0_epc_i,
  input  logic [31:0]           current_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic                  ctrl_busy,
  output logic                  stall_timeout,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  localparam logic [NUM_STAGES-1:0] ALL_STAGES = '1;
  localparam logic [31:0]           TIMEOUT_W  = 32'(TIMEOUT);

  ctrl_state_e           state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  flush_q, flush_d;
  logic [31:0]           new_pc_q, new_pc_d;
  logic [31:0]           run_q, run_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_STAGES-1:0] req_mask;
  logic [NUM_STAGES-1:0] stall_c;

  // Stages beyond NUM_STAGES simply do not exist, which clamps the depth.
  function automatic logic [NUM_STAGES-1:0] depth_mask(input logic [7:0] depth);
    logic [NUM_STAGES-1:0] m;
    for (int k = 0; k < NUM_STAGES; k++) m[k] = (k < int'(depth));
    return m;
  endfunction

  always_comb begin
    req_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (stall_req[i]) req_mask = req_mask | depth_mask(STALL_DEPTHS[8*i +: 8]);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stall_c = '0;
    case (state_q)
      IDLE: begin
        if (excepttype_i != 32'h0) begin
          pc_d    = exc_vector(excepttype_i, cp0_epc_i, current_pc);
          stall_c = ALL_STAGES;
          state_d = mem_busy ? DRAIN : REDIRECT;
        end else begin
          stall_c = req_mask;
        end
      end
      DRAIN: begin
        stall_c = ALL_STAGES;
        if (!mem_busy) state_d = REDIRECT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // flush/new_pc are registered so they line up with the REDIRECT state.
    flush_d  = (state_d == REDIRECT);
    new_pc_d = flush_d ? pc_d : 32'h0;
  end

  always_comb begin
    run_d = 32'h0;
    if (stall != '0) run_d = (run_q >= TIMEOUT_W) ? run_q : run_q + 32'd1;
    timeout_d = timeout_q | (run_d >= TIMEOUT_W);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pc_q      <= 32'h0;
      flush_q   <= 1'b0;
      new_pc_q  <= 32'h0;
      run_q     <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  // Mask is forced quiet while reset is held so downstream stages see no freeze.
  assign stall         = resetn ? stall_c : '0;
  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign ctrl_busy     = (state_q != IDLE);
  assign stall_timeout = timeout_q;

  sat_counter32 u_stall_cnt (
    .clk     (clk),
    .rst_n   (resetn),
    .en_i    (stall != '0),
    .count_o (stall_cycles)
  );

  sat_counter32 u_flush_cnt (
    .clk     (clk),
    .rst_n   (resetn),
    .en_i    (flush_q),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Self-checking bench for pipe_ctrl_v2 with a cycle-level behavioural model.
module tb_pipe_ctrl_v2;

  localparam int          TO     = 16;
  localparam logic [39:0] DEPTHS = {8'd4, 8'd5, 8'd8, 8'd8, 8'd8};

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  stall_req;
  logic        mem_busy;
  logic [31:0] excepttype_i, cp0_epc_i, current_pc;
  logic [8:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ctrl_busy, stall_timeout;
  logic [31:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_v2 #(
    .NUM_STAGES   (9),
    .NUM_SRC      (5),
    .STALL_DEPTHS (DEPTHS),
    .TIMEOUT      (TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stall_req     (stall_req),
    .mem_busy      (mem_busy),
    .excepttype_i  (excepttype_i),
    .cp0_epc_i     (cp0_epc_i),
    .current_pc    (current_pc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .ctrl_busy     (ctrl_busy),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  // Model: m_hold = exception accepted, waiting for the bus; m_fire = flush this cycle.
  bit          m_fire, m_hold, m_to;
  logic [31:0] m_target, m_stc, m_flc;
  int          m_run;
  logic [8:0]  exp_stall;
  bit          exp_flush, exp_busy;
  logic [31:0] exp_newpc;

  function automatic logic [31:0] ref_vec(input logic [31:0] c, input logic [31:0] epc,
                                          input logic [31:0] pc);
    case (c)
      32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c, 32'h0d,
      32'h12, 32'h14, 32'h15: return 32'hbfc00380;
      32'h11, 32'h13:         return 32'hbfc00200;
      32'h0e:                 return epc;
      32'hffffffff:           return pc + 32'd4;
      default:                return 32'h0;
    endcase
  endfunction

  function automatic logic [8:0] ref_mask(input logic [4:0] req);
    logic [8:0] m;
    int d;
    m = '0;
    for (int i = 0; i < 5; i++) begin
      if (req[i]) begin
        d = int'(DEPTHS[8*i +: 8]);
        if (d > 9) d = 9;
        m = m | 9'((1 << d) - 1);
      end
    end
    return m;
  endfunction

  task automatic model_clear();
    m_fire = 0; m_hold = 0; m_to = 0; m_run = 0;
    m_target = '0; m_stc = '0; m_flc = '0;
  endtask

  task automatic model_eval();
    exp_flush = m_fire;
    exp_newpc = m_fire ? m_target : 32'h0;
    exp_busy  = m_fire | m_hold;
    if (!resetn || m_fire)                  exp_stall = '0;
    else if (m_hold || excepttype_i != 0)   exp_stall = '1;
    else                                    exp_stall = ref_mask(stall_req);
  endtask

  task automatic model_next();
    model_eval();
    if (exp_stall != 0) begin
      if (m_stc != 32'hffffffff) m_stc = m_stc + 1;
      m_run++;
      if (m_run >= TO) m_to = 1;
    end else begin
      m_run = 0;
    end
    if (exp_flush && m_flc != 32'hffffffff) m_flc = m_flc + 1;
    if (m_fire) m_fire = 0;
    else if (m_hold) begin
      if (!mem_busy) begin m_hold = 0; m_fire = 1; end
    end else if (excepttype_i != 0) begin
      m_target = ref_vec(excepttype_i, cp0_epc_i, current_pc);
      if (mem_busy) m_hold = 1; else m_fire = 1;
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 0; stall_req = '0; mem_busy = 0;
    excepttype_i = '0; cp0_epc_i = '0; current_pc = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (stall !== 9'h0) begin n_bad++; $display("FAIL reset_stall got=%h want=0", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got=%b want=0", flush); end
    n_cmp++; if (new_pc !== 32'h0) begin n_bad++; $display("FAIL reset_new_pc got=%h want=0", new_pc); end
    n_cmp++; if (ctrl_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", ctrl_busy); end
    n_cmp++; if ({stall_timeout, stall_cycles, flush_count} !== 65'h0) begin
      n_bad++; $display("FAIL reset_counters got=%b/%0d/%0d want=0/0/0", stall_timeout, stall_cycles, flush_count);
    end
    tick();
  endtask

  task automatic test_stall_priority();
    logic [4:0] reqs [7] = '{5'b11000, 5'b11010, 5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b00000};
    logic [8:0] want [7] = '{9'h01f, 9'h0ff, 9'h0ff, 9'h00f, 9'h01f, 9'h0ff, 9'h000};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      stall_req = reqs[i];
      #1;
      n_cmp++; if (stall !== want[i]) begin n_bad++; $display("FAIL stall_prio[%0d] got=%b want=%b", i, stall, want[i]); end
      tick();
    end
  endtask

  task automatic test_syscall();
    do_reset();
    stall_req = 5'b00001; excepttype_i = 32'h08;
    #1;
    n_cmp++; if (stall !== 9'h1ff) begin n_bad++; $display("FAIL sys_stall got=%b want=1ff", stall); end
    tick();
    excepttype_i = 0; stall_req = 5'b11111;
    #1;
    n_cmp++; if (flush !== 1'b1 || new_pc !== 32'hbfc00380) begin
      n_bad++; $display("FAIL sys_flush got=%b/%h want=1/bfc00380", flush, new_pc);
    end
    n_cmp++; if (stall !== 9'h0) begin n_bad++; $display("FAIL sys_redirect_stall got=%b want=0", stall); end
    tick();
    stall_req = 0;
    #1;
    n_cmp++; if (flush_count !== 32'd1 || flush !== 1'b0 || new_pc !== 32'h0) begin
      n_bad++; $display("FAIL sys_after got=%0d/%b/%h want=1/0/0", flush_count, flush, new_pc);
    end
    tick();
  endtask

  task automatic test_eret_drain();
    do_reset();
    excepttype_i = 32'h0e; cp0_epc_i = 32'h80001234; mem_busy = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) excepttype_i = 0;
      if (c == 3) mem_busy = 0;
      #1;
      n_cmp++; if (stall !== 9'h1ff || flush !== 1'b0) begin
        n_bad++; $display("FAIL eret_drain[%0d] got=%b/%b want=1ff/0", c, stall, flush);
      end
      tick();
    end
    #1;
    n_cmp++; if (flush !== 1'b1 || new_pc !== 32'h80001234) begin
      n_bad++; $display("FAIL eret_flush got=%b/%h want=1/80001234", flush, new_pc);
    end
    tick();
    n_cmp++; if (stall_cycles !== 32'd4 || flush_count !== 32'd1) begin
      n_bad++; $display("FAIL eret_counts got=%0d/%0d want=4/1", stall_cycles, flush_count);
    end
  endtask

  task automatic test_refetch_wrap();
    do_reset();
    excepttype_i = 32'hffffffff; current_pc = 32'hfffffffc;
    #1;
    tick();
    excepttype_i = 0;
    #1;
    n_cmp++; if (flush !== 1'b1 || new_pc !== 32'h0) begin
      n_bad++; $display("FAIL refetch got=%b/%h want=1/00000000", flush, new_pc);
    end
    tick();
  endtask

  task automatic test_second_exc();
    int flushes;
    do_reset();
    excepttype_i = 32'h11; mem_busy = 1;
    tick();
    excepttype_i = 32'h0c;
    tick();
    excepttype_i = 0; mem_busy = 0;
    tick();
    #1;
    n_cmp++; if (flush !== 1'b1 || new_pc !== 32'hbfc00200) begin
      n_bad++; $display("FAIL second_exc got=%b/%h want=1/bfc00200", flush, new_pc);
    end
    tick();
    flushes = 0;
    for (int c = 0; c < 4; c++) begin
      if (flush) flushes++;
      tick();
    end
    n_cmp++; if (flushes != 0 || flush_count !== 32'd1) begin
      n_bad++; $display("FAIL second_exc_count got=%0d/%0d want=0/1", flushes, flush_count);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    stall_req = 5'b00001;
    repeat (15) tick();
    n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL wd_early got=%b want=0", stall_timeout); end
    tick();
    n_cmp++; if (stall_timeout !== 1'b1 || stall_cycles !== 32'd16) begin
      n_bad++; $display("FAIL wd_trip got=%b/%0d want=1/16", stall_timeout, stall_cycles);
    end
    stall_req = 0;
    repeat (3) tick();
    n_cmp++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got=%b want=1", stall_timeout); end
  endtask

  task automatic test_reset_in_drain();
    int flushes;
    do_reset();
    excepttype_i = 32'h01; mem_busy = 1;
    tick();
    excepttype_i = 0;
    tick();
    #2 resetn = 0;
    model_clear();
    #1;
    n_cmp++; if ({stall, flush, new_pc, ctrl_busy, stall_timeout, stall_cycles, flush_count} !== '0) begin
      n_bad++; $display("FAIL rst_drain got=%b/%b/%h/%b/%b/%0d/%0d want=all 0",
                        stall, flush, new_pc, ctrl_busy, stall_timeout, stall_cycles, flush_count);
    end
    @(posedge clk);
    #1 resetn = 1; mem_busy = 0;
    flushes = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (flush || ctrl_busy) flushes++;
      tick();
    end
    n_cmp++; if (flushes != 0) begin n_bad++; $display("FAIL rst_no_flush got=%0d want=0", flushes); end
  endtask

  task automatic test_random();
    logic [31:0] codes [7] = '{32'h01, 32'h08, 32'h0e, 32'h11, 32'h15, 32'hffffffff, 32'h07};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      stall_req    = 5'($urandom) & 5'($urandom) & 5'($urandom);
      mem_busy     = ($urandom_range(0, 2) == 0);
      cp0_epc_i    = $urandom;
      current_pc   = $urandom;
      excepttype_i = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
      #1;
      model_eval();
      n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall[%0d] got=%b want=%b", c, stall, exp_stall); end
      n_cmp++; if (flush !== exp_flush || new_pc !== exp_newpc) begin
        n_bad++; $display("FAIL rnd_flush[%0d] got=%b/%h want=%b/%h", c, flush, new_pc, exp_flush, exp_newpc);
      end
      n_cmp++; if (ctrl_busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy[%0d] got=%b want=%b", c, ctrl_busy, exp_busy); end
      n_cmp++; if (stall_cycles !== m_stc || flush_count !== m_flc || stall_timeout !== m_to) begin
        n_bad++; $display("FAIL rnd_counters[%0d] got=%0d/%0d/%b want=%0d/%0d/%b",
                          c, stall_cycles, flush_count, stall_timeout, m_stc, m_flc, m_to);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_syscall();
    test_eret_drain();
    test_refetch_wrap();
    test_second_exc();
    test_watchdog();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
